// File: rtl/sda_action_control_regs.sv
// AXI4-Lite start/status/parameter slave for the action kernel; serves kernel parameter reads over SELF channels.
// Optional RUN cycle counter at 0x08 is built when SDA_ACTION_CYCLE_COUNT_EN is defined.
module sda_action_control_regs #(
   parameter int NUM_PARAMS = 16,
   parameter int DEC_BITS   = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s_axi_awaddr,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        go_0Ready,
   input  logic        go_0Stop,
   input  logic        done_0Ready,
   output logic        done_0Stop,
   input  logic        paramaddr_0Ready,
   input  logic [31:0] paramaddr_0Data,
   output logic        paramaddr_0Stop,
   output logic        paramdata_0Ready,
   output logic [31:0] paramdata_0Data,
   input  logic        paramdata_0Stop
);

   localparam int PW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
   localparam int AW = DEC_BITS - 2;
   localparam logic [AW-1:0] PBASE = AW'(16);
   localparam logic [AW-1:0] PEND  = AW'(16 + NUM_PARAMS);

   typedef enum logic [1:0] {IDLE, START, RUN} state_t;

   state_t        state;
   logic [31:0]   params [NUM_PARAMS];
   logic          done_flag;
   logic [31:0]   rd_mux;

   // Word addresses within the decoded window
   logic [AW-1:0] wa, ra;
   logic          w_param, r_param;
   logic [PW-1:0] w_idx, r_idx;

   assign wa      = s_axi_awaddr[DEC_BITS-1:2];
   assign ra      = s_axi_araddr[DEC_BITS-1:2];
   assign w_param = (wa >= PBASE) && (wa < PEND);
   assign r_param = (ra >= PBASE) && (ra < PEND);
   assign w_idx   = PW'(wa - PBASE);
   assign r_idx   = PW'(ra - PBASE);

   logic wr_fire, start_req, clr_req, go_xfer, done_xfer;

   assign wr_fire   = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
   assign start_req = wr_fire && (wa == '0) && s_axi_wdata[0];
   assign clr_req   = wr_fire && (wa == '0) && s_axi_wdata[2];
   assign go_xfer   = go_0Ready & ~go_0Stop;
   assign done_xfer = done_0Ready & ~done_0Stop;

   assign s_axi_rresp = 2'b00;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awaddr[31:DEC_BITS], s_axi_awaddr[1:0], s_axi_araddr[31:DEC_BITS],
                        s_axi_araddr[1:0], s_axi_awcache, s_axi_awprot, s_axi_arcache, s_axi_arprot};

   // Write channel and parameter register file
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= 2'b00;
         for (int i = 0; i < NUM_PARAMS; i++) params[i] <= '0;
      end else begin
         s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
         s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
         if (wr_fire) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (w_param && state != IDLE) ? 2'b10 : 2'b00;
            if (w_param && state == IDLE) begin
               for (int b = 0; b < 4; b++)
                  if (s_axi_wstrb[b]) params[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
      end
   end

`ifdef SDA_ACTION_CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;

   // Counts every edge spent in RUN, including the one that retires the done token
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycle_cnt <= '0;
      else if (go_xfer)
         cycle_cnt <= '0;
      else if (state == RUN && cycle_cnt != '1)
         cycle_cnt <= cycle_cnt + 32'd1;
   end
`endif

   always_comb begin
      rd_mux = '0;
      if (ra == AW'(1)) rd_mux = {30'b0, done_flag, state != IDLE};
`ifdef SDA_ACTION_CYCLE_COUNT_EN
      if (ra == AW'(2)) rd_mux = cycle_cnt;
`endif
      if (r_param) rd_mux = params[r_idx];
   end

   // Read channel: a single read in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
      end else begin
         s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
         if (s_axi_arready && s_axi_arvalid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

   // Action FSM with registered SELF-channel controls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         go_0Ready  <= 1'b0;
         done_0Stop <= 1'b1;
         done_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_req) begin
               state     <= START;
               go_0Ready <= 1'b1;
            end
            START: if (go_xfer) begin
               state      <= RUN;
               go_0Ready  <= 1'b0;
               done_0Stop <= 1'b0;
            end
            RUN: if (done_xfer) begin
               state      <= IDLE;
               done_0Stop <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               go_0Ready  <= 1'b0;
               done_0Stop <= 1'b1;
            end
         endcase
         if (done_xfer)
            done_flag <= 1'b1;
         else if (clr_req)
            done_flag <= 1'b0;
      end
   end

   // Parameter server: index accepted only while no data is pending
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         paramaddr_0Stop  <= 1'b0;
         paramdata_0Ready <= 1'b0;
         paramdata_0Data  <= '0;
      end else if (paramaddr_0Ready && !paramaddr_0Stop) begin
         paramaddr_0Stop  <= 1'b1;
         paramdata_0Ready <= 1'b1;
         paramdata_0Data  <= (paramaddr_0Data < 32'(NUM_PARAMS)) ? params[paramaddr_0Data[PW-1:0]] : '0;
      end else if (paramdata_0Ready && !paramdata_0Stop) begin
         paramaddr_0Stop  <= 1'b0;
         paramdata_0Ready <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sda_action_control_regs.sv
// Self-checking bench for sda_action_control_regs: AXI register access, action FSM, parameter server, async reset.
`timescale 1ns/1ps
module tb_sda_action_control_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] s_axi_awaddr = '0;
   logic [3:0]  s_axi_awcache = '0;
   logic [2:0]  s_axi_awprot = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [31:0] s_axi_araddr = '0;
   logic [3:0]  s_axi_arcache = '0;
   logic [2:0]  s_axi_arprot = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic        go_0Ready;
   logic        go_0Stop = 1'b0;
   logic        done_0Ready = 1'b0;
   logic        done_0Stop;
   logic        paramaddr_0Ready = 1'b0;
   logic [31:0] paramaddr_0Data = '0;
   logic        paramaddr_0Stop;
   logic        paramdata_0Ready;
   logic [31:0] paramdata_0Data;
   logic        paramdata_0Stop = 1'b0;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sda_action_control_regs dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .go_0Ready(go_0Ready), .go_0Stop(go_0Stop),
      .done_0Ready(done_0Ready), .done_0Stop(done_0Stop),
      .paramaddr_0Ready(paramaddr_0Ready), .paramaddr_0Data(paramaddr_0Data),
      .paramaddr_0Stop(paramaddr_0Stop),
      .paramdata_0Ready(paramdata_0Ready), .paramdata_0Data(paramdata_0Data),
      .paramdata_0Stop(paramdata_0Stop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit ok = 0;
      resp = 2'bxx;
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (s_axi_awready && s_axi_wready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL aw_timeout addr=%h awready never seen", addr);
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
         return;
      end
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (s_axi_bvalid) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL b_timeout addr=%h bvalid never seen", addr);
         return;
      end
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit ok = 0;
      data = 'x; resp = 2'bxx;
      s_axi_araddr = addr; s_axi_arvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (s_axi_arready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL ar_timeout addr=%h arready never seen", addr);
         s_axi_arvalid = 1'b0;
         return;
      end
      tick();
      s_axi_arvalid = 1'b0;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (s_axi_rvalid) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL r_timeout addr=%h rvalid never seen", addr);
         return;
      end
      data = s_axi_rdata; resp = s_axi_rresp;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
   endtask

   // Sends one index; reports whether data was valid in the cycle right after the index transfer
   task automatic param_req(input logic [31:0] idx, output logic [31:0] data, output logic on_time);
      paramaddr_0Data = idx; paramaddr_0Ready = 1'b1;
      tick();
      paramaddr_0Ready = 1'b0;
      on_time = paramdata_0Ready;
      data = paramdata_0Data;
      for (int k = 0; k < 20; k++) begin
         if (paramdata_0Ready && !paramdata_0Stop) begin tick(); break; end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d, e; logic [1:0] r;
      reset = 1'b0;
      repeat (3) tick();
      n_chk++; if (go_0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_go_ready got=%b exp=0", go_0Ready); end
      n_chk++; if (done_0Stop !== 1'b1) begin n_fail++; $display("FAIL reset_done_stop got=%b exp=1", done_0Stop); end
      n_chk++; if (paramdata_0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_pd_ready got=%b exp=0", paramdata_0Ready); end
      n_chk++; if (paramaddr_0Stop !== 1'b0) begin n_fail++; $display("FAIL reset_pa_stop got=%b exp=0", paramaddr_0Stop); end
      n_chk++; if ({s_axi_awready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 4'b0) begin
         n_fail++; $display("FAIL reset_axi_outs got=%b exp=0000", {s_axi_awready, s_axi_bvalid, s_axi_arready, s_axi_rvalid});
      end
      reset = 1'b1;
      tick();
      exp_q.push_back(32'h0);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", d, e); end
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL reset_status_rresp got=%b exp=00", r); end
   endtask

   task automatic test_params();
      logic [31:0] d, e; logic [1:0] r; logic ot;
      axi_write(32'h4C, 32'hDEADBEEF, 4'hF, r);
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL param3_bresp got=%b exp=00", r); end
      exp_q.push_back(32'hDEADBEEF);
      axi_read(32'h4C, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param3_axi_read got=%h exp=%h", d, e); end
      exp_q.push_back(32'hDEADBEEF);
      param_req(32'd3, d, ot);
      e = exp_q.pop_front();
      n_chk++; if (ot !== 1'b1) begin n_fail++; $display("FAIL param3_latency got_ready=%b exp=1", ot); end
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param3_kernel got=%h exp=%h", d, e); end
      exp_q.push_back(32'h0);
      param_req(32'd20, d, ot);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param20_kernel got=%h exp=%h", d, e); end
      axi_write(32'h44, 32'h11223344, 4'hF, r);
      axi_write(32'h44, 32'h0000AB00, 4'h2, r);
      exp_q.push_back(32'h1122AB44);
      axi_read(32'h44, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param1_wstrb got=%h exp=%h", d, e); end
      exp_q.push_back(32'hDEADBEEF);
      axi_read(32'h1000_004C, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL upper_addr_ignored got=%h exp=%h", d, e); end
      axi_write(32'h3C, 32'hFFFFFFFF, 4'hF, r);
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL unmapped_bresp got=%b exp=00", r); end
      exp_q.push_back(32'h0);
      axi_read(32'h3C, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e || r !== 2'b00) begin n_fail++; $display("FAIL unmapped_read got=%h/%b exp=%h/00", d, r, e); end
`ifndef SDA_ACTION_CYCLE_COUNT_EN
      exp_q.push_back(32'h0);
      axi_read(32'h08, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL no_counter_read got=%h exp=%h", d, e); end
`endif
   endtask

   task automatic test_action();
      logic [31:0] d, e; logic [1:0] r;
      go_0Stop = 1'b1;
      axi_write(32'h00, 32'h1, 4'hF, r);
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL start_bresp got=%b exp=00", r); end
      for (int k = 0; k < 5; k++) begin
         n_chk++; if (go_0Ready !== 1'b1) begin n_fail++; $display("FAIL go_ready_hold cycle=%0d got=%b exp=1", k, go_0Ready); end
         tick();
      end
      exp_q.push_back(32'h1);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL status_busy got=%h exp=%h", d, e); end
      go_0Stop = 1'b0;
      tick();
      n_chk++; if (go_0Ready !== 1'b0 || done_0Stop !== 1'b0) begin
         n_fail++; $display("FAIL go_transfer got go=%b dstop=%b exp go=0 dstop=0", go_0Ready, done_0Stop);
      end
      repeat (9) tick();
      n_chk++; if (done_0Stop !== 1'b0) begin n_fail++; $display("FAIL run_done_stop got=%b exp=0", done_0Stop); end
      done_0Ready = 1'b1;
      tick();
      done_0Ready = 1'b0;
      n_chk++; if (done_0Stop !== 1'b1) begin n_fail++; $display("FAIL done_transfer_stop got=%b exp=1", done_0Stop); end
      exp_q.push_back(32'h2);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL status_done got=%h exp=%h", d, e); end
`ifdef SDA_ACTION_CYCLE_COUNT_EN
      exp_q.push_back(32'd10);
      axi_read(32'h08, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL cycle_count got=%0d exp=%0d", d, e); end
`endif
   endtask

   task automatic test_run_writes();
      logic [31:0] d, e; logic [1:0] r; logic ot; bit ok;
      axi_write(32'h00, 32'h4, 4'hF, r);
      exp_q.push_back(32'h0);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL done_clr got=%h exp=%h", d, e); end
      axi_write(32'h00, 32'h1, 4'hF, r);
      n_chk++; if (done_0Stop !== 1'b0) begin n_fail++; $display("FAIL run_entered got_dstop=%b exp=0", done_0Stop); end
      axi_write(32'h4C, 32'h12345678, 4'hF, r);
      n_chk++; if (r !== 2'b10) begin n_fail++; $display("FAIL param_run_bresp got=%b exp=10", r); end
      exp_q.push_back(32'hDEADBEEF);
      axi_read(32'h4C, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param_run_unchanged got=%h exp=%h", d, e); end
      axi_write(32'h00, 32'h1, 4'hF, r);
      n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL start_in_run_bresp got=%b exp=00", r); end
      exp_q.push_back(32'h1);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL status_run got=%h exp=%h", d, e); end
      exp_q.push_back(32'hDEADBEEF);
      param_req(32'd3, d, ot);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL param_in_run got=%h exp=%h", d, e); end
      // DONE_CLR write lands on the same edge as the done transfer
      s_axi_awaddr = 32'h00; s_axi_wdata = 32'h4; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (s_axi_awready) begin ok = 1; break; end
      end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL clr_done_aw got=timeout exp=awready"); end
      done_0Ready = 1'b1;
      tick();
      done_0Ready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      exp_q.push_back(32'h2);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL clr_with_done got=%h exp=%h", d, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, e, rd; logic [1:0] r, rr; logic ot;
      logic [31:0] idx_tab [4];
      int c0;
      idx_tab[0] = 3; idx_tab[1] = 5; idx_tab[2] = 1; idx_tab[3] = 20;
      fork
         axi_write(32'h54, 32'hCAFEF00D, 4'hF, r);
         axi_read(32'h4C, rd, rr);
      join
      n_chk++; if (r !== 2'b00 || rd !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL simultaneous_rw got=%b/%h exp=00/deadbeef", r, rd);
      end
      exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'h1122AB44); exp_q.push_back(32'h0);
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         param_req(idx_tab[i], d, ot);
         e = exp_q.pop_front();
         n_chk++; if (d !== e || ot !== 1'b1) begin
            n_fail++; $display("FAIL param_stream idx=%0d got=%h/%b exp=%h/1", idx_tab[i], d, ot, e);
         end
      end
      n_chk++; if (cyc - c0 !== 8) begin n_fail++; $display("FAIL param_stream_cycles got=%0d exp=8", cyc - c0); end
      paramdata_0Stop = 1'b1;
      exp_q.push_back(32'h1122AB44);
      paramaddr_0Data = 32'd1; paramaddr_0Ready = 1'b1;
      tick();
      paramaddr_0Ready = 1'b0;
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
         n_chk++; if (paramdata_0Ready !== 1'b1 || paramdata_0Data !== e || paramaddr_0Stop !== 1'b1) begin
            n_fail++; $display("FAIL param_backpressure cycle=%0d got=%b/%h/%b exp=1/%h/1", k, paramdata_0Ready, paramdata_0Data, paramaddr_0Stop, e);
         end
         tick();
      end
      paramdata_0Stop = 1'b0;
      tick();
      n_chk++; if (paramdata_0Ready !== 1'b0 || paramaddr_0Stop !== 1'b0) begin
         n_fail++; $display("FAIL param_release got=%b/%b exp=0/0", paramdata_0Ready, paramaddr_0Stop);
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] d, e; logic [1:0] r;
      axi_write(32'h00, 32'h1, 4'hF, r);
      paramdata_0Stop = 1'b1;
      paramaddr_0Data = 32'd3; paramaddr_0Ready = 1'b1;
      tick();
      paramaddr_0Ready = 1'b0;
      n_chk++; if (paramdata_0Ready !== 1'b1 || done_0Stop !== 1'b0) begin
         n_fail++; $display("FAIL midrun_setup got pd=%b dstop=%b exp pd=1 dstop=0", paramdata_0Ready, done_0Stop);
      end
      #3 reset = 1'b0;
      #1;
      n_chk++; if (go_0Ready !== 1'b0 || done_0Stop !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_fsm got go=%b dstop=%b exp go=0 dstop=1", go_0Ready, done_0Stop);
      end
      n_chk++; if (paramdata_0Ready !== 1'b0 || paramdata_0Data !== 32'h0 || paramaddr_0Stop !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_param got=%b/%h/%b exp=0/0/0", paramdata_0Ready, paramdata_0Data, paramaddr_0Stop);
      end
      paramdata_0Stop = 1'b0;
      tick(); tick();
      #2 reset = 1'b1;
      tick();
      exp_q.push_back(32'h0);
      axi_read(32'h04, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL status_after_reset got=%h exp=%h", d, e); end
      exp_q.push_back(32'h0);
      axi_read(32'h4C, d, r);
      e = exp_q.pop_front();
      n_chk++; if (d !== e) begin n_fail++; $display("FAIL params_after_reset got=%h exp=%h", d, e); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_params();
      test_action();
      test_run_writes();
      test_back_to_back();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
